// File: rtl/uart_if.sv
// uart_if: client-side transmit handshake, loopback control and receive status for uart_core
interface uart_if #(parameter int DATA_SIZE = 8);
   logic [DATA_SIZE-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic tx_busy;
   logic loopback;
   logic [DATA_SIZE-1:0] rx_data;
   logic rx_valid;
   logic rx_parity_err;
   logic rx_frame_err;
   logic rx_busy;
   modport master (
      output tx_data, tx_valid, loopback,
      input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
   );
   modport slave (
      input  tx_data, tx_valid, loopback,
      output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
   );
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with shared bit timing, parity/stop options, mid-bit
// receive sampling with false-start rejection, and an internal tx->rx loopback
module uart_core #(
   parameter int DATA_SIZE    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic clk,
   input  logic rst,
   uart_if.slave bus,
   input  logic rx,
   output logic tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_SIZE);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] DATA_END = IW'(DATA_SIZE - 1);
   localparam logic [IW-1:0] STOP_END = IW'(STOP_BITS - 1);
   localparam bit HAS_PAR = PARITY_MODE != 0;
   localparam bit ODD     = PARITY_MODE == 2;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

   state_t tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [IW-1:0] tx_idx_q, tx_idx_d;
   logic [DATA_SIZE-1:0] tx_sh_q, tx_sh_d;
   logic tx_par_q, tx_par_d, tx_q, tx_d, tx_ready_q, tx_ready_d;

   always_comb begin
      tx_st_d = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_idx_d = tx_idx_q;
      tx_sh_d = tx_sh_q;
      tx_par_d = tx_par_q;
      tx_d = tx_q;
      tx_ready_d = tx_ready_q;
      if (tx_st_q == IDLE) begin
         tx_cnt_d = '0;
         tx_idx_d = '0;
         if (bus.tx_valid) begin
            tx_st_d = START;
            tx_sh_d = bus.tx_data;
            tx_par_d = ^bus.tx_data ^ ODD;
            tx_d = 1'b0;
            tx_ready_d = 1'b0;
         end
      end else if (tx_cnt_q == BIT_END) begin
         tx_cnt_d = '0;
         tx_idx_d = '0;
         case (tx_st_q)
            START: begin
               tx_st_d = DATA;
               tx_d = tx_sh_q[0];
            end
            DATA: if (tx_idx_q == DATA_END) begin
               tx_st_d = HAS_PAR ? PAR : STOP;
               tx_d = HAS_PAR ? tx_par_q : 1'b1;
            end else begin
               tx_idx_d = tx_idx_q + 1'b1;
               tx_sh_d = tx_sh_q >> 1;
               tx_d = tx_sh_q[1];
            end
            PAR: begin
               tx_st_d = STOP;
               tx_d = 1'b1;
            end
            default: if (tx_idx_q == STOP_END) begin
               tx_st_d = IDLE;
               tx_ready_d = 1'b1;
            end else tx_idx_d = tx_idx_q + 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st_q <= IDLE;
         tx_cnt_q <= '0;
         tx_idx_q <= '0;
         tx_sh_q <= '0;
         tx_par_q <= 1'b0;
         tx_q <= 1'b1;
         tx_ready_q <= 1'b1;
      end else begin
         tx_st_q <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_idx_q <= tx_idx_d;
         tx_sh_q <= tx_sh_d;
         tx_par_q <= tx_par_d;
         tx_q <= tx_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign tx = bus.loopback | tx_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.tx_busy = ~tx_ready_q;

   state_t rx_st_q, rx_st_d;
   logic s1_q, s2_q, line, sample;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [IW-1:0] rx_idx_q, rx_idx_d;
   logic [DATA_SIZE-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic perr_q, perr_d, ferr_q, ferr_d;
   logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_busy_q;

   assign line = bus.loopback ? tx_q : s2_q;
   // the start bit is checked half a bit in; every later bit one full bit after that
   assign sample = rx_cnt_q == (rx_st_q == START ? MID : BIT_END);

   always_comb begin
      rx_st_d = rx_st_q;
      rx_cnt_d = sample ? '0 : rx_cnt_q + 1'b1;
      rx_idx_d = rx_idx_q;
      rx_sh_d = rx_sh_q;
      perr_d = perr_q;
      ferr_d = ferr_q;
      rx_data_d = rx_data_q;
      rx_perr_d = rx_perr_q;
      rx_ferr_d = rx_ferr_q;
      rx_valid_d = 1'b0;
      case (rx_st_q)
         IDLE: begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            if (!line) rx_st_d = START;
         end
         WAIT_HIGH: if (line) rx_st_d = IDLE;
         START: if (sample) rx_st_d = line ? IDLE : DATA;
         DATA: if (sample) begin
            rx_sh_d = {line, rx_sh_q[DATA_SIZE-1:1]};
            rx_idx_d = rx_idx_q + 1'b1;
            if (rx_idx_q == DATA_END) begin
               rx_st_d = HAS_PAR ? PAR : STOP;
               rx_idx_d = '0;
            end
         end
         PAR: if (sample) begin
            perr_d = line ^ (^rx_sh_q) ^ ODD;
            rx_st_d = STOP;
         end
         default: if (sample) begin
            ferr_d = ferr_q | ~line;
            rx_idx_d = rx_idx_q + 1'b1;
            if (rx_idx_q == STOP_END) begin
               rx_st_d = (ferr_q | ~line) ? WAIT_HIGH : IDLE;
               rx_data_d = rx_sh_q;
               rx_perr_d = perr_q;
               rx_ferr_d = ferr_q | ~line;
               rx_valid_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         rx_st_q <= IDLE;
         rx_cnt_q <= '0;
         rx_idx_q <= '0;
         rx_sh_q <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         rx_data_q <= '0;
         rx_perr_q <= 1'b0;
         rx_ferr_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_busy_q <= 1'b0;
      end else begin
         s1_q <= rx;
         s2_q <= s1_q;
         rx_st_q <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_idx_q <= rx_idx_d;
         rx_sh_q <= rx_sh_d;
         perr_q <= perr_d;
         ferr_q <= ferr_d;
         rx_data_q <= rx_data_d;
         rx_perr_q <= rx_perr_d;
         rx_ferr_q <= rx_ferr_d;
         rx_valid_q <= rx_valid_d;
         rx_busy_q <= rx_st_d != IDLE;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_parity_err = rx_perr_q;
   assign bus.rx_frame_err = rx_ferr_q;
   assign bus.rx_busy = rx_busy_q;
endmodule
